m3key_cond: RTL and testbench
=============================

M3KEY_COND -- requirements
Module: m3key_cond

Interface
REQ-001 Parameter DEBOUNCE_CYC, 10000: consecutive clkI samples needed to accept a key change (10 ms at 1 MHz).
REQ-002 Parameter REPEAT_DELAY, 500000: cycles from the first adjust pulse to the first auto-repeat pulse.
REQ-003 Parameter REPEAT_PERIOD, 100000: cycles between auto-repeat pulses.
REQ-004 Parameter KEY_ACTIVE_LOW, 1: 1 means raw key pin low = pressed.
REQ-005 Reset is synchronous and active-high, and the block has a single clock.
REQ-006 clkI  in  1  1 MHz system clock; all logic clocks on its rising edge.
REQ-007 rstI  in  1  synchronous active-high reset.
REQ-008 startKeyI, stopKeyI, invKeyI  in  1 each  asynchronous raw start, force-stop and reverse key pins.
REQ-009 spdIncKeyI, spdDecKeyI, pwrIncKeyI, pwrDecKeyI  in  1 each  asynchronous raw adjust key pins.
REQ-010 m3startO  out  1  one-cycle start pulse to motor602_top.m3startI.
REQ-011 m3forceStopO  out  1  level; high while stop key is debounced-pressed.
REQ-012 m3invRotateO  out  1  level; rotation direction, toggled per reverse press.
REQ-013 m3speedINCo, m3speedDECo, m3powerINCo, m3powerDECo  out  1 each  one-cycle adjust pulses with auto-repeat.
REQ-014 keyStateO  out  7  debounced pressed levels {pwrDec,pwrInc,spdDec,spdInc,inv,stop,start}, bit0 = start.

Function
REQ-015 Each raw key shall pass a 2-flop synchronizer, then be normalized to pressed = 1 per KEY_ACTIVE_LOW.
REQ-016 Per key, the debounce counter shall increment while the synchronized level differs from the stable level and clear to 0 on agreement.
REQ-017 The stable level shall flip, and its counter clear, in the cycle after DEBOUNCE_CYC consecutive differing samples.
REQ-018 Latency from a raw pin edge to a stable flip shall be 2 + DEBOUNCE_CYC cycles; glitches shorter than DEBOUNCE_CYC samples shall have no effect.
REQ-019 All pulse and toggle outputs shall be registered, asserting in the cycle after the stable-level rising edge.
REQ-020 m3startO shall pulse once per start press, with no repeat.
REQ-021 m3invRotateO shall toggle once per reverse-key press.
REQ-022 m3forceStopO shall equal the stable stop level, registered, with one cycle of latency.
REQ-023 Each adjust key shall have an FSM with states IDLE, DELAY and REPEAT, plus a cycle counter sized $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
REQ-024 IDLE->DELAY when the key is pressed and its partner (INC<->DEC of the same pair) is not pressed; one pulse is issued and the counter is cleared.
REQ-025 DELAY->REPEAT when the counter reaches REPEAT_DELAY-1; one pulse is issued and the counter is cleared.
REQ-026 In REPEAT, one pulse shall be issued and the counter cleared each time it reaches REPEAT_PERIOD-1.
REQ-027 Any state shall go to IDLE with no pulse on key release.
REQ-028 Conflict: when both keys of a pair are pressed, both FSMs shall go to IDLE and stay there; when one key is released, the remaining pressed key shall re-enter DELAY with a fresh pulse.
REQ-029 Force-stop priority: while stop is stable-pressed, start pulses, inv toggles and all adjust pulses shall be suppressed and adjust FSMs held in IDLE.
REQ-030 A press that occurs during force-stop shall not be replayed after stop release.
REQ-031 A start edge coinciding with the stop rising edge shall be suppressed.
REQ-032 Counters shall saturate and never wrap; REPEAT_DELAY and REPEAT_PERIOD shall be at least 2.

Reset
REQ-033 While rstI is high, synchronizer flops and stable levels shall load the released value, so that no edge is generated at reset release.
REQ-034 While rstI is high, all counters shall be 0, FSMs IDLE, and every output 0, including m3invRotateO.
REQ-035 rstI asserted mid-debounce or mid-repeat shall abort the operation with no pulse in the reset cycle or in the cycle following it.

Structure
REQ-036 Shared package m3key_pkg shall hold the adjust-FSM state enum, the keyStateO bit-index constants and the default timing constants.
REQ-037 Sub-module m3key_debounce (synchronizer, counter and stable level for one key) shall be instantiated 7 times; edge, repeat and priority logic shall live in m3key_cond.

Verification (DEBOUNCE_CYC=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, KEY_ACTIVE_LOW=1)
REQ-038 startKeyI low for 3 cycles, then high -> no m3startO; low held for 10 cycles -> exactly one m3startO pulse, 7 cycles after the falling edge.
REQ-039 spdIncKeyI held 50 cycles after stable -> m3speedINCo pulses at relative cycles 0, 20, 25, 30, 35, 40, 45; release -> no further pulse.
REQ-040 spdInc held, then spdDec pressed -> both silent while both held; release spdInc -> immediate m3speedDECo pulse, then repeat after 20 cycles.
REQ-041 stopKeyI held, then pwrInc and start pressed -> m3forceStopO=1 and no pulses; release stop with pwrInc still held -> pwrInc FSM enters DELAY with one pulse.
REQ-042 invKeyI pressed 3 times -> m3invRotateO goes 0->1->0->1; rstI pulse -> 0 with no spurious pulse after release.
REQ-043 rstI asserted in the REPEAT state with a key held -> all outputs 0 during reset; key still held after release -> fresh DEBOUNCE_CYC qualification, then the first pulse.

Source files
------------

// File: rtl/m3key_pkg.sv
// Shared definitions for the motor key conditioner: adjust-FSM states,
// keyStateO bit positions and default timing constants.
package m3key_pkg;

  typedef enum logic [1:0] {
    ADJ_IDLE   = 2'd0,
    ADJ_DELAY  = 2'd1,
    ADJ_REPEAT = 2'd2
  } adjState_t;

  localparam int KEY_START   = 0;
  localparam int KEY_STOP    = 1;
  localparam int KEY_INV     = 2;
  localparam int KEY_SPD_INC = 3;
  localparam int KEY_SPD_DEC = 4;
  localparam int KEY_PWR_INC = 5;
  localparam int KEY_PWR_DEC = 6;
  localparam int NUM_KEYS    = 7;

  localparam int DEF_DEBOUNCE_CYC   = 10000;
  localparam int DEF_REPEAT_DELAY   = 500000;
  localparam int DEF_REPEAT_PERIOD  = 100000;
  localparam int DEF_KEY_ACTIVE_LOW = 1;

endpackage

// File: rtl/m3key_debounce.sv
// One key: 2-flop synchronizer, polarity normalization and a counter that
// flips the stable pressed level after DEBOUNCE_CYC consecutive differing samples.
module m3key_debounce
  import m3key_pkg::*;
#(
  parameter int DEBOUNCE_CYC   = DEF_DEBOUNCE_CYC,
  parameter int KEY_ACTIVE_LOW = DEF_KEY_ACTIVE_LOW
) (
  input  logic clkI,
  input  logic rstI,
  input  logic rawI,
  output logic stableO
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic RELEASED_RAW = (KEY_ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic syncA, syncB, pressed;
  logic [CNT_W-1:0] cnt;

  assign pressed = syncB ^ RELEASED_RAW;

  // Reset loads the released level everywhere so no edge appears on release.
  always_ff @(posedge clkI) begin
    if (rstI) begin
      syncA   <= RELEASED_RAW;
      syncB   <= RELEASED_RAW;
      stableO <= 1'b0;
      cnt     <= '0;
    end else begin
      syncA <= rawI;
      syncB <= syncA;
      if (pressed != stableO) begin
        if (cnt == CNT_LAST) begin
          stableO <= ~stableO;
          cnt     <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/m3key_cond.sv
// Key conditioner for the motor controller: debounces seven keys and turns
// them into start/toggle pulses, a force-stop level and auto-repeat adjust pulses.
module m3key_cond
  import m3key_pkg::*;
#(
  parameter int DEBOUNCE_CYC   = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD  = DEF_REPEAT_PERIOD,
  parameter int KEY_ACTIVE_LOW = DEF_KEY_ACTIVE_LOW
) (
  input  logic                clkI,
  input  logic                rstI,
  input  logic                startKeyI,
  input  logic                stopKeyI,
  input  logic                invKeyI,
  input  logic                spdIncKeyI,
  input  logic                spdDecKeyI,
  input  logic                pwrIncKeyI,
  input  logic                pwrDecKeyI,
  output logic                m3startO,
  output logic                m3forceStopO,
  output logic                m3invRotateO,
  output logic                m3speedINCo,
  output logic                m3speedDECo,
  output logic                m3powerINCo,
  output logic                m3powerDECo,
  output logic [NUM_KEYS-1:0] keyStateO
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(CNT_MAX);

  logic [NUM_KEYS-1:0] rawKeys, keyState;
  logic [3:0] adjPulse;
  logic startPrev, invPrev, stopHeld;

  assign rawKeys  = {pwrDecKeyI, pwrIncKeyI, spdDecKeyI, spdIncKeyI, invKeyI, stopKeyI, startKeyI};
  assign stopHeld = keyState[KEY_STOP];
  assign keyStateO = keyState;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : gDeb
    m3key_debounce #(
      .DEBOUNCE_CYC  (DEBOUNCE_CYC),
      .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
    ) uDeb (
      .clkI   (clkI),
      .rstI   (rstI),
      .rawI   (rawKeys[k]),
      .stableO(keyState[k])
    );
  end

  // Edges are taken against the live stop level, so a start edge that lands
  // together with the stop rising edge is also swallowed.
  always_ff @(posedge clkI) begin
    if (rstI) begin
      startPrev    <= 1'b0;
      invPrev      <= 1'b0;
      m3startO     <= 1'b0;
      m3forceStopO <= 1'b0;
      m3invRotateO <= 1'b0;
    end else begin
      startPrev    <= keyState[KEY_START];
      invPrev      <= keyState[KEY_INV];
      m3startO     <= keyState[KEY_START] & ~startPrev & ~stopHeld;
      m3forceStopO <= stopHeld;
      if (keyState[KEY_INV] & ~invPrev & ~stopHeld) m3invRotateO <= ~m3invRotateO;
    end
  end

  // Adjust keys 0..3 = spdInc, spdDec, pwrInc, pwrDec; partner is index ^ 1.
  for (genvar a = 0; a < 4; a++) begin : gAdj
    localparam int SELF    = KEY_SPD_INC + a;
    localparam int PARTNER = KEY_SPD_INC + (a ^ 1);

    adjState_t state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic allowed, pulse, pulseNext;

    assign allowed = keyState[SELF] & ~keyState[PARTNER] & ~stopHeld;

    always_ff @(posedge clkI) begin
      if (rstI) begin
        state <= ADJ_IDLE;
        cnt   <= '0;
        pulse <= 1'b0;
      end else begin
        state <= stateNext;
        cnt   <= cntNext;
        pulse <= pulseNext;
      end
    end

    always_comb begin
      stateNext = state;
      cntNext   = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
      if (!allowed) begin
        stateNext = ADJ_IDLE;
        cntNext   = '0;
      end else begin
        case (state)
          ADJ_IDLE: begin
            stateNext = ADJ_DELAY;
            cntNext   = '0;
          end
          ADJ_DELAY: begin
            if (cnt == DELAY_LAST) begin
              stateNext = ADJ_REPEAT;
              cntNext   = '0;
            end
          end
          ADJ_REPEAT: begin
            if (cnt == PERIOD_LAST) cntNext = '0;
          end
          default: begin
            stateNext = ADJ_IDLE;
            cntNext   = '0;
          end
        endcase
      end
    end

    always_comb begin
      pulseNext = 1'b0;
      if (allowed) begin
        case (state)
          ADJ_IDLE:   pulseNext = 1'b1;
          ADJ_DELAY:  pulseNext = (cnt == DELAY_LAST);
          ADJ_REPEAT: pulseNext = (cnt == PERIOD_LAST);
          default:    pulseNext = 1'b0;
        endcase
      end
    end

    assign adjPulse[a] = pulse;
  end

  assign m3speedINCo = adjPulse[0];
  assign m3speedDECo = adjPulse[1];
  assign m3powerINCo = adjPulse[2];
  assign m3powerDECo = adjPulse[3];

endmodule

// File: tb/tb_m3key_cond.sv
// Bench for m3key_cond: directed key scenarios plus random key activity,
// compared every cycle against a behavioural model of the key rules.
module tb_m3key_cond;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 5;
  localparam int OW  = 14;

  logic clkI = 1'b0;
  logic rstI;
  logic [6:0] rawPress;
  logic startKeyI, stopKeyI, invKeyI, spdIncKeyI, spdDecKeyI, pwrIncKeyI, pwrDecKeyI;
  logic m3startO, m3forceStopO, m3invRotateO;
  logic m3speedINCo, m3speedDECo, m3powerINCo, m3powerDECo;
  logic [6:0] keyStateO;

  // active-low pins: rawPress bit = 1 means the key is pressed
  assign startKeyI  = ~rawPress[0];
  assign stopKeyI   = ~rawPress[1];
  assign invKeyI    = ~rawPress[2];
  assign spdIncKeyI = ~rawPress[3];
  assign spdDecKeyI = ~rawPress[4];
  assign pwrIncKeyI = ~rawPress[5];
  assign pwrDecKeyI = ~rawPress[6];

  m3key_cond #(
    .DEBOUNCE_CYC  (DEB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP),
    .KEY_ACTIVE_LOW(1)
  ) dut (
    .clkI        (clkI),
    .rstI        (rstI),
    .startKeyI   (startKeyI),
    .stopKeyI    (stopKeyI),
    .invKeyI     (invKeyI),
    .spdIncKeyI  (spdIncKeyI),
    .spdDecKeyI  (spdDecKeyI),
    .pwrIncKeyI  (pwrIncKeyI),
    .pwrDecKeyI  (pwrDecKeyI),
    .m3startO    (m3startO),
    .m3forceStopO(m3forceStopO),
    .m3invRotateO(m3invRotateO),
    .m3speedINCo (m3speedINCo),
    .m3speedDECo (m3speedDECo),
    .m3powerINCo (m3powerINCo),
    .m3powerDECo (m3powerDECo),
    .keyStateO   (keyStateO)
  );

  // clock / reset
  always #5 clkI = ~clkI;

  // counters and scoreboard
  int nChecks = 0;
  int nPass   = 0;
  int cyc     = 0;
  int startCnt = 0;
  int lastStartCyc = 0;
  int incQ[$];
  logic [OW-1:0] exp_q[$];

  // reference model state
  logic [6:0] mStable, mStablePrev, mP1, mP2;
  logic [DEB-1:0] mHist [7];
  int mAge [4];
  logic mInv;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Model: a key becomes stable once the last DEB synchronized samples all
  // disagree with it; an adjust key that has been usable for `age` cycles
  // pulses at age 0, RD, RD+RP, RD+2*RP, ...
  task automatic model_step();
    logic [6:0] nextStable;
    logic [3:0] adjP;
    logic startP, stopOut, allowed;
    int age;
    if (rstI) begin
      mStable = '0; mStablePrev = '0; mP1 = '0; mP2 = '0; mInv = 1'b0;
      for (int k = 0; k < 7; k++) mHist[k] = '0;
      for (int a = 0; a < 4; a++) mAge[a] = -1;
      exp_q.push_back('0);
    end else begin
      startP  = mStable[0] & ~mStablePrev[0] & ~mStable[1];
      stopOut = mStable[1];
      if (mStable[2] & ~mStablePrev[2] & ~mStable[1]) mInv = ~mInv;
      for (int a = 0; a < 4; a++) begin
        allowed = mStable[3 + a] & ~mStable[3 + (a ^ 1)] & ~mStable[1];
        if (allowed) begin
          mAge[a]++;
          age = mAge[a];
          adjP[a] = (age == 0) || (age == RD) || (age > RD && ((age - RD) % RP) == 0);
        end else begin
          mAge[a] = -1;
          adjP[a] = 1'b0;
        end
      end
      nextStable = mStable;
      for (int k = 0; k < 7; k++) begin
        mHist[k] = {mHist[k][DEB-2:0], mP2[k]};
        if (mHist[k] == {DEB{~mStable[k]}}) nextStable[k] = ~mStable[k];
      end
      mStablePrev = mStable;
      mStable = nextStable;
      mP2 = mP1;
      mP1 = rawPress;
      exp_q.push_back({adjP, mInv, stopOut, startP, mStable});
    end
  endtask

  // driver: one clock cycle, model at the rising edge, compare at the falling edge
  task automatic tick();
    logic [OW-1:0] got, e;
    @(posedge clkI);
    model_step();
    @(negedge clkI);
    cyc++;
    got = {m3powerDECo, m3powerINCo, m3speedDECo, m3speedINCo,
           m3invRotateO, m3forceStopO, m3startO, keyStateO};
    e = exp_q.pop_front();
    check_eq("outputs", 32'(got), 32'(e));
    if (m3startO) begin
      startCnt++;
      lastStartCyc = cyc;
    end
    if (m3speedINCo) incQ.push_back(cyc);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset(input int n);
    rstI = 1'b1;
    run(n);
    rstI = 1'b0;
  endtask

  initial begin
    int p;
    int expRel[7];
    logic [6:0] bitSel;
    expRel = '{0, 20, 25, 30, 35, 40, 45};
    rstI = 1'b1;
    rawPress = '0;
    @(negedge clkI);
    do_reset(3);
    run(5);

    // start glitch of 3 samples, then a real press
    rawPress[0] = 1'b1; run(3); rawPress[0] = 1'b0; run(15);
    check_eq("start_glitch_cnt", 32'(startCnt), 32'd0);
    p = cyc;
    rawPress[0] = 1'b1; run(10); rawPress[0] = 1'b0; run(15);
    check_eq("start_press_cnt", 32'(startCnt), 32'd1);
    check_eq("start_latency", 32'(lastStartCyc - p), 32'd7);

    // spdInc held 50 cycles after becoming stable
    incQ.delete();
    p = cyc;
    rawPress[3] = 1'b1; run(50); rawPress[3] = 1'b0; run(30);
    check_eq("inc_pulse_cnt", 32'(incQ.size()), 32'd7);
    if (incQ.size() == 7) begin
      check_eq("inc_first_latency", 32'(incQ[0] - p), 32'd7);
      for (int i = 1; i < 7; i++) check_eq("inc_rel_cycle", 32'(incQ[i] - incQ[0]), 32'(expRel[i]));
    end

    // speed pair conflict
    rawPress[3] = 1'b1; run(30);
    rawPress[4] = 1'b1; run(30);
    rawPress[3] = 1'b0; run(40);
    rawPress = '0; run(15);

    // force-stop priority
    rawPress[1] = 1'b1; run(10);
    rawPress[5] = 1'b1; rawPress[0] = 1'b1; run(20);
    rawPress[1] = 1'b0; run(30);
    rawPress = '0; run(15);

    // reverse key three times, then reset
    for (int i = 0; i < 3; i++) begin
      rawPress[2] = 1'b1; run(8); rawPress[2] = 1'b0; run(8);
    end
    do_reset(2);
    run(10);

    // reset during REPEAT with the key still held
    rawPress[6] = 1'b1; run(40);
    do_reset(3);
    run(40);
    rawPress = '0; run(15);

    // random key activity with glitches and occasional resets
    for (int s = 0; s < 80; s++) begin
      int r;
      r = $urandom_range(0, 9);
      bitSel = 7'd1 << $urandom_range(0, 6);
      if (r == 0) begin
        do_reset($urandom_range(1, 3));
      end else if (r < 3) begin
        rawPress = rawPress ^ bitSel;
        run($urandom_range(1, 3));
        rawPress = rawPress ^ bitSel;
        run($urandom_range(1, 5));
      end else begin
        rawPress = rawPress ^ bitSel;
        run($urandom_range(1, 40));
      end
    end
    rawPress = '0;
    run(20);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
